// File: rtl/vertex_submit_master.sv
// vertex_submit_master: takes whole triangles from the geometry stage and
// replays each one as three single-beat bus writes (addr 0/1/2 = A/B/C).
// The triangles are buffered in a small FIFO.
// Optional build macro SUBMIT_DOORBELL_EN adds a fourth write per triangle.
// That write goes to address 3 and carries the triangle sequence number.
module vertex_submit_master #(
   parameter int FIFO_DEPTH = 4,
   parameter int VERTEX_W   = 64,
   parameter int COUNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tri_valid,
   output logic                tri_ready,
   input  logic [VERTEX_W-1:0] tri_vertex_a,
   input  logic [VERTEX_W-1:0] tri_vertex_b,
   input  logic [VERTEX_W-1:0] tri_vertex_c,
   output logic                write,
   output logic                read,
   output logic [2:0]          address,
   output logic [VERTEX_W-1:0] writedata,
   input  logic                waitrequest,
   output logic                busy,
   output logic [COUNT_W-1:0]  tri_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [2:0] {
      IDLE, WR_A, WR_B, WR_C
`ifdef SUBMIT_DOORBELL_EN
      , WR_DB
`endif
   } state_t;

   state_t state, state_nxt;

   logic [FIFO_DEPTH-1:0][3*VERTEX_W-1:0] mem;
   logic [PW-1:0]       wr_ptr, rd_ptr, wr_nxt, rd_nxt, occ;
   logic [3*VERTEX_W-1:0] head;
   logic                push, pop, accept, empty, full_nxt, avail_q;

`ifdef SUBMIT_DOORBELL_EN
   logic [COUNT_W-1:0]  cnt_inc;
   assign cnt_inc = tri_count + COUNT_W'(1);
`endif

   assign read     = 1'b0;
   assign push     = tri_valid & tri_ready;
   assign accept   = write & ~waitrequest;
   assign empty    = (wr_ptr == rd_ptr);
   assign occ      = wr_ptr - rd_ptr;
   assign wr_nxt   = wr_ptr + PW'(push);
   assign rd_nxt   = rd_ptr + PW'(pop);
   assign full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
   // Head entry as it will be after this edge's pop, so a back-to-back A beat sees the next triangle
   assign head     = mem[rd_nxt[AW-1:0]];
   assign busy     = ~empty | write;

   // Triangle storage; a slot is never overwritten while it is the head because pushes stop when full
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {tri_vertex_c, tri_vertex_b, tri_vertex_a};
   end

   // FIFO pointers, registered ready and the one-cycle-delayed non-empty flag that paces IDLE exit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         tri_ready <= 1'b1;
         avail_q   <= 1'b0;
      end else begin
         wr_ptr    <= wr_nxt;
         rd_ptr    <= rd_nxt;
         tri_ready <= ~full_nxt;
         avail_q   <= ~empty;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and pop; a beat only advances on an accepted write
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: if (avail_q && !empty) state_nxt = WR_A;
         WR_A: if (accept) state_nxt = WR_B;
         WR_B: if (accept) state_nxt = WR_C;
`ifdef SUBMIT_DOORBELL_EN
         WR_C: if (accept) state_nxt = WR_DB;
         WR_DB: begin
            if (accept) begin
               pop       = 1'b1;
               state_nxt = (occ > PW'(1)) ? WR_A : IDLE;
            end
         end
`else
         WR_C: begin
            if (accept) begin
               pop       = 1'b1;
               state_nxt = (occ > PW'(1)) ? WR_A : IDLE;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Bus outputs registered from the next state; they hold while stalled because state and head hold
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write     <= 1'b0;
         address   <= 3'd0;
         writedata <= '0;
      end else begin
         write <= (state_nxt != IDLE);
         case (state_nxt)
            WR_A: begin
               address   <= 3'd0;
               writedata <= head[VERTEX_W-1:0];
            end
            WR_B: begin
               address   <= 3'd1;
               writedata <= head[2*VERTEX_W-1:VERTEX_W];
            end
            WR_C: begin
               address   <= 3'd2;
               writedata <= head[3*VERTEX_W-1:2*VERTEX_W];
            end
`ifdef SUBMIT_DOORBELL_EN
            WR_DB: begin
               address   <= 3'd3;
               writedata <= VERTEX_W'(cnt_inc);
            end
`endif
            default: begin
               address   <= 3'd0;
               writedata <= '0;
            end
         endcase
      end
   end

   // Completed-triangle counter, wraps naturally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)   tri_count <= '0;
      else if (pop) tri_count <= tri_count + COUNT_W'(1);
   end

endmodule
